// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage: word size, the ecall
// encoding, PC increment and the fetch state encoding.
package cpu_pkg;

  localparam int          XLEN       = 32;
  localparam logic [31:0] INSN_ECALL = 32'h0000_0073;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    FS_BOOT,
    FS_RUN,
    FS_HALT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory side (pc/iready/ins), redirect input
// from execute, and the valid/ready channel toward decode.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [XLEN-1:0] pc;
  logic            iready;
  logic [XLEN-1:0] ins;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_ins;
  logic            halted;

  // The fetch unit drives the bus.
  modport master (
    output pc, iready, out_valid, out_pc, out_ins, halted,
    input  ins, redirect, redirect_pc, out_ready
  );

  // Memory, execute and decode together form the other side.
  modport slave (
    input  pc, iready, out_valid, out_pc, out_ins, halted,
    output ins, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, ins} pairs. Flush wins over push and
// pop. Head outputs read as zero while empty. DEPTH must be a power of two
// so the pointers wrap naturally.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_pc,
  input  logic [XLEN-1:0] push_ins,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_ins,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] ins_mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            push_ok;
  logic            pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;
  assign head_pc  = empty ? '0 : pc_mem[rptr];
  assign head_ins = empty ? '0 : ins_mem[rptr];

  // Storage is data only; it is never reset, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wptr]  <= push_pc;
      ins_mem[wptr] <= push_ins;
    end
  end

  // Pointers and occupancy; flush clears everything in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches one word per cycle from imem into
// a small FIFO toward decode, flushes on redirect and stops after ecall.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_nx;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            iready;
  logic            out_valid;

  // State register; any reset returns to BOOT for one idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_BOOT;
    else        state <= state_nx;
  end

  // Next state plus the fetch/deliver gating; redirect overrides everything.
  always_comb begin
    state_nx  = state;
    iready    = 1'b0;
    out_valid = 1'b0;
    if (!bus.redirect) begin
      iready    = (state == FS_RUN) && (fifo_count < CW'(DEPTH));
      out_valid = !fifo_empty;
    end
    case (state)
      FS_BOOT: state_nx = FS_RUN;
      FS_RUN:  if (iready && bus.ins == INSN_ECALL) state_nx = FS_HALT;
      FS_HALT: state_nx = FS_HALT;
      default: state_nx = FS_BOOT;
    endcase
    if (bus.redirect) state_nx = FS_RUN;
  end

  assign push = iready && !fifo_full;
  assign pop  = out_valid && bus.out_ready;

  // Program counter: redirect target (word aligned) or sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pc_q <= RESET_PC;
    else if (bus.redirect) pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (push)         pc_q <= pc_q + PC_STEP;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect),
    .push     (push),
    .pop      (pop),
    .push_pc  (pc_q),
    .push_ins (bus.ins),
    .head_pc  (bus.out_pc),
    .head_ins (bus.out_ins),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.pc        = pc_q;
  assign bus.iready    = iready;
  assign bus.out_valid = out_valid;
  assign bus.halted    = (state == FS_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based reference model checked every cycle on
// the falling edge, plus directed scenarios with literal expectations.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory contents; unlisted addresses hold a non-ecall word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      32'h10:  return 32'h0000_0073;
      default: return (a << 8) | 32'h13;
    endcase
  endfunction

  assign bus.ins = bus.iready ? mem_word(bus.pc) : 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched words, fetch address, boot/halt flags.
  logic [31:0] q_pc [$];
  logic [31:0] q_ins[$];
  logic [31:0] m_pc   = RST_PC;
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q_pc.delete();
      q_ins.delete();
      m_pc   = RST_PC;
      m_boot = 1'b1;
      m_halt = 1'b0;
      chk("rst_pc", bus.pc, RST_PC);
      chk("rst_iready", 32'(bus.iready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_pc", bus.out_pc, 32'd0);
      chk("rst_out_ins", bus.out_ins, 32'd0);
      chk("rst_halted", 32'(bus.halted), 32'd0);
    end else begin
      bit          e_rdy;
      bit          e_vld;
      logic [31:0] w;
      e_rdy = !m_boot && !m_halt && (q_pc.size() < DEPTH) && !bus.redirect;
      e_vld = (q_pc.size() != 0) && !bus.redirect;
      chk("m_iready", 32'(bus.iready), 32'(e_rdy));
      chk("m_out_valid", 32'(bus.out_valid), 32'(e_vld));
      chk("m_pc", bus.pc, m_pc);
      chk("m_halted", 32'(bus.halted), 32'(m_halt));
      if (q_pc.size() != 0) begin
        chk("m_out_pc", bus.out_pc, q_pc[0]);
        chk("m_out_ins", bus.out_ins, q_ins[0]);
      end else begin
        chk("m_out_pc_empty", bus.out_pc, 32'd0);
        chk("m_out_ins_empty", bus.out_ins, 32'd0);
      end
      // Advance the model to what the next rising edge must produce.
      if (bus.redirect) begin
        q_pc.delete();
        q_ins.delete();
        m_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
        m_halt = 1'b0;
      end else begin
        if (e_vld && bus.out_ready) begin
          void'(q_pc.pop_front());
          void'(q_ins.pop_front());
        end
        if (e_rdy) begin
          w = mem_word(m_pc);
          q_pc.push_back(m_pc);
          q_ins.push_back(w);
          m_pc = m_pc + 32'd4;
          if (w == 32'h0000_0073) m_halt = 1'b1;
        end
      end
      m_boot = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_iready", 32'(bus.iready), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);

    // Boot then stream three words with decode always ready.
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("boot_iready", 32'(bus.iready), 32'd0);
    step();
    chk("run_iready", 32'(bus.iready), 32'd1);
    chk("run_pc", bus.pc, 32'h0);
    step();
    chk("stream0_pc", bus.out_pc, 32'h0);
    chk("stream0_ins", bus.out_ins, 32'h0050_0093);
    step();
    chk("stream1_pc", bus.out_pc, 32'h4);
    chk("stream1_ins", bus.out_ins, 32'h00A0_0113);
    step();
    chk("stream2_pc", bus.out_pc, 32'h8);
    chk("stream2_ins", bus.out_ins, 32'h0020_81B3);
    step();
    step();

    // ecall at 0x10 has just been pushed.
    chk("ecall_halted", 32'(bus.halted), 32'd1);
    chk("ecall_iready", 32'(bus.iready), 32'd0);
    chk("ecall_pc", bus.pc, 32'h14);
    chk("ecall_out_pc", bus.out_pc, 32'h10);
    chk("ecall_out_ins", bus.out_ins, 32'h0000_0073);
    step();
    chk("halt_drained", 32'(bus.out_valid), 32'd0);
    chk("halt_pc_hold", bus.pc, 32'h14);

    // Redirect out of HALT.
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect = 1'b0;
    #1;
    chk("resume_pc", bus.pc, 32'h40);
    chk("resume_halted", 32'(bus.halted), 32'd0);
    step();
    chk("resume_out_pc", bus.out_pc, 32'h40);
    chk("resume_out_ins", bus.out_ins, 32'h0000_4013);

    // Backpressure from the first push after a redirect to 0.
    bus.out_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect = 1'b0;
    step();
    step();
    chk("bp_full_iready", 32'(bus.iready), 32'd0);
    chk("bp_full_pc", bus.pc, 32'h8);
    chk("bp_head_pc", bus.out_pc, 32'h0);
    step();
    chk("bp_pc_hold", bus.pc, 32'h8);
    bus.out_ready = 1'b1;
    step();
    chk("bp_drain1_pc", bus.out_pc, 32'h4);
    chk("bp_drain1_iready", 32'(bus.iready), 32'd1);
    step();
    chk("bp_resume_pc", bus.out_pc, 32'h8);
    chk("bp_resume_ins", bus.out_ins, 32'h0020_81B3);

    // Redirect flush with two entries queued.
    bus.out_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h20;
    step();
    bus.redirect = 1'b0;
    step();
    step();
    chk("fl_full_head", bus.out_pc, 32'h20);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    #1;
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_iready", 32'(bus.iready), 32'd0);
    step();
    bus.redirect = 1'b0;
    #1;
    chk("fl_pc", bus.pc, 32'h100);
    chk("fl_empty", 32'(bus.out_valid), 32'd0);
    step();
    chk("fl_new_valid", 32'(bus.out_valid), 32'd1);
    chk("fl_new_pc", bus.out_pc, 32'h100);
    chk("fl_new_ins", bus.out_ins, 32'h0001_0013);
    step();

    // Asynchronous reset between edges while full.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_iready", 32'(bus.iready), 32'd0);
    chk("arst_pc", bus.pc, RST_PC);
    step();
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("post_rst_pc", bus.out_pc, 32'h8);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the instruction memory (`imem`) and feeds decode. It owns the program counter, asserts `iready` to `imem`, and captures each returned word with its PC into a small FIFO. That FIFO is presented to decode through a valid/ready handshake. It also handles branch/jump redirects (flushing in-flight fetches) and halts fetching on `ecall` until redirected.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `DEPTH`, default 2: fetch FIFO entries. Must be 2 or 4.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  out  32  fetch address to `imem`.
- `iready`  out  1  fetch enable to `imem`. `imem` returns `ins` = 0 when low.
- `ins`  in  32  instruction from `imem`. Combinational, valid in the same cycle as `pc` when `iready`=1.
- `redirect`  in  1  branch/jump taken: flush and refetch.
- `redirect_pc`  in  32  new fetch target. Bits [1:0] are ignored and forced to 0.
- `out_valid`  out  1  FIFO head valid toward decode.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_pc`  out  32  PC of the head entry.
- `out_ins`  out  32  instruction of the head entry.
- `halted`  out  1  fetch is stopped after `ecall`.

## Operation
- **States:**
  - BOOT: one cycle after reset release. `iready`=0.
  - RUN: normal fetching.
  - HALT: fetching stopped after `ecall`.
- **Transitions:**
  - BOOT→RUN unconditionally.
  - RUN→HALT when an enqueued word equals 32'h0000_0073 (`ecall`).
  - HALT→RUN on `redirect`.
  - Reset → BOOT from any state.
- **`iready`:** `iready` = (state==RUN) && (count < DEPTH) && !`redirect`. It is combinational from registered state and `redirect`.
- **Push:**
  - When `iready`=1, {`pc`, `ins`} is written at the FIFO tail on the clock edge.
  - `pc` advances by 4 on the same edge. The add is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- **Pop:** when `out_valid` && `out_ready`, the head is removed. `out_valid` = (count != 0) && !`redirect`.
- **Simultaneous push and pop:** both occur and count is unchanged. When the FIFO is full, push is blocked even if a pop happens the same cycle.
- **Redirect:**
  - Redirect has the highest priority: the FIFO is flushed (count←0, pointers←0) and `pc` ← {`redirect_pc`[31:2], 2'b00}.
  - The state becomes RUN, from either RUN or HALT.
  - No push or pop occurs in the redirect cycle, and `out_valid` is 0 in that cycle.
- **HALT:** `pc` holds at the address after `ecall`. Entries already queued remain poppable. `halted`=1.
- **Reset values:** `pc`=RESET_PC, `iready`=0, `out_valid`=0, `out_pc`=0, `out_ins`=0, `halted`=0, count=0, state=BOOT. FIFO storage need not be reset, but `out_pc`/`out_ins` must be driven to 0 while empty.
- **Mid-operation reset:** asynchronous. All of the above values apply immediately, and FIFO contents are discarded.

## Timing
- The fetch word is sampled in the same cycle `pc` is presented; there is no memory wait state.
- Latency from push to `out_valid`=1 is 1 cycle.
- Sustained throughput is 1 instruction per cycle when `out_ready` is held high.
- After `out_ready` has been low for DEPTH cycles, the FIFO is full and `iready` drops the next cycle.
- After `redirect`, the first word from the new target is pushed 1 cycle later and visible on `out_*` 2 cycles after the redirect cycle.
- `redirect` and `out_ready` are inputs combinationally used in the same cycle. There is no path from `ins` to `iready`.

## Structure
- Shared package `cpu_pkg` holds:
  - `XLEN`=32
  - `INSN_ECALL`=32'h0000_0073
  - `PC_STEP`=4
  - the fetch state enum (`FS_BOOT`, `FS_RUN`, `FS_HALT`)
- Sub-module `fetch_fifo`: a DEPTH-entry synchronous FIFO of {pc, ins} with push, pop, flush, count, full and empty. Its flush has priority over push and pop.
- `fetch_unit` contains the PC register, the state machine, and the `iready`/`out_valid` gating.

## Test plan
- **Reset and boot:** hold `rst_n`=0 for 3 cycles with RESET_PC=0 → `pc`=0, `iready`=0, `out_valid`=0. On the first cycle after release `iready` stays 0 (BOOT), and it goes to 1 on the second.
- **Streaming:** `imem` holds 0x00500093, 0x00A00113, 0x002081B3 at addresses 0/4/8 and `out_ready`=1 → `out_pc`/`out_ins` show (0, 0x00500093), (4, 0x00A00113), (8, 0x002081B3) on consecutive cycles.
- **Backpressure:** `out_ready`=0 from the first push → after 2 pushes (DEPTH=2) `iready`=0 and `pc`=8 holds. Raising `out_ready` drains pc 0 then 4 in order, and fetching resumes at 8 with no word lost or duplicated.
- **Redirect flush:** with 2 entries queued, pulse `redirect`=1 with `redirect_pc`=0x0000_0103 → `out_valid`=0 that cycle. Next cycle `pc`=0x100; the following cycle `out_pc`=0x100. The old entries never appear.
- **Ecall halt:** the word at 0x10 is 0x00000073 → after its push, `halted`=1, `iready`=0 and `pc`=0x14. The ecall entry is still delivered, and `redirect` to 0x40 resumes fetching.
- **Async reset mid-stream:** drop `rst_n` between clock edges while the FIFO is full → `out_valid` and `iready` fall immediately, and `pc`=RESET_PC without waiting for a clock edge.
